// File: rtl/fifo_async_top.sv
// Single-clock FIFO: register array with extended read/write pointers.
// Latency: write visible to a read on the next edge; read data registered, valid 1 cycle after accept.
// Backpressure: w_full blocks writes (dropped), r_empty blocks reads (ignored, rdata holds).
//
// Ports:
//   w_clk    single clock, rising edge; both ports sample on it
//   wrst_n   asynchronous active-low reset; clears pointers and rdata
//   w_en     write request, accepted when !w_full
//   wdata    write data
//   r_en     read request, accepted when !r_empty
//   w_full   FIFO holds MEMORY_DEPTH words
//   r_empty  FIFO holds no words
//   rdata    registered read data
module fifo_async_top #(
  parameter int MEMORY_WIDTH = 4,
  parameter int MEMORY_DEPTH = 4,
  parameter int ADDRESS_SIZE = 2
) (
  input  logic                    w_clk,
  input  logic                    wrst_n,
  input  logic                    w_en,
  input  logic [MEMORY_WIDTH-1:0] wdata,
  input  logic                    r_en,
  output logic                    w_full,
  output logic                    r_empty,
  output logic [MEMORY_WIDTH-1:0] rdata
);

  logic [MEMORY_WIDTH-1:0] mem [MEMORY_DEPTH];
  logic [ADDRESS_SIZE:0]   wptr;
  logic [ADDRESS_SIZE:0]   rptr;
  logic                    wr_acc;
  logic                    rd_acc;

  // The extra pointer MSB tells a full lap (full) apart from no lap (empty)
  // when the address bits coincide.
  assign r_empty = (wptr == rptr);
  assign w_full  = (wptr[ADDRESS_SIZE] != rptr[ADDRESS_SIZE]) &&
                   (wptr[ADDRESS_SIZE-1:0] == rptr[ADDRESS_SIZE-1:0]);

  assign wr_acc = w_en && !w_full;
  assign rd_acc = r_en && !r_empty;

  // Storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge w_clk) begin
    if (wr_acc) begin
      mem[wptr[ADDRESS_SIZE-1:0]] <= wdata;
    end
  end

  always_ff @(posedge w_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr <= '0;
    end else if (wr_acc) begin
      wptr <= wptr + 1'b1;
    end
  end

  // A read on a simultaneously-written empty FIFO is dropped because
  // r_empty was still set at the edge, so mem is never read stale.
  always_ff @(posedge w_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      rptr  <= '0;
      rdata <= '0;
    end else if (rd_acc) begin
      rdata <= mem[rptr[ADDRESS_SIZE-1:0]];
      rptr  <= rptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_async_top.sv
// Testbench for fifo_async_top: queue scoreboard of written words, checked on every edge.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: model drops writes at 4 words and reads at 0 words, independent of DUT state.
module tb_fifo_async_top;

  logic       w_clk;
  logic       wrst_n;
  logic       w_en;
  logic [3:0] wdata;
  logic       r_en;
  logic       w_full;
  logic       r_empty;
  logic [3:0] rdata;

  int n_checks;
  int n_errors;

  logic [3:0] sb_q[$];
  logic [3:0] exp_rdata;

  fifo_async_top #(
    .MEMORY_WIDTH(4),
    .MEMORY_DEPTH(4),
    .ADDRESS_SIZE(2)
  ) dut (
    .w_clk  (w_clk),
    .wrst_n (wrst_n),
    .w_en   (w_en),
    .wdata  (wdata),
    .r_en   (r_en),
    .w_full (w_full),
    .r_empty(r_empty),
    .rdata  (rdata)
  );

  initial begin
    w_clk = 1'b0;
    forever #5 w_clk = ~w_clk;
  end

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".rdata"}, {4'h0, rdata}, {4'h0, exp_rdata});
    check({tag, ".empty"}, {7'h0, r_empty}, {7'h0, sb_q.size() == 0});
    check({tag, ".full"},  {7'h0, w_full},  {7'h0, sb_q.size() == 4});
  endtask

  // Drive one cycle's request, advance the model at the edge, then compare.
  task automatic do_cycle(input string tag, input logic w, input logic [3:0] d, input logic r);
    bit wr_ok;
    bit rd_ok;
    @(negedge w_clk);
    w_en  = w;
    wdata = d;
    r_en  = r;
    @(posedge w_clk);
    wr_ok = w && (sb_q.size() < 4);
    rd_ok = r && (sb_q.size() > 0);
    if (rd_ok) exp_rdata = sb_q.pop_front();
    if (wr_ok) sb_q.push_back(d);
    #1;
    check_state(tag);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    exp_rdata = 4'h0;
    w_en      = 1'b0;
    r_en      = 1'b0;
    wdata     = 4'h0;
    wrst_n    = 1'b0;

    // 1. Reset: flags and rdata at reset values, no pointer motion.
    #2;
    check_state("rst_async");
    repeat (2) @(posedge w_clk);
    #1;
    check_state("rst_held");
    @(negedge w_clk);
    wrst_n = 1'b1;
    do_cycle("idle", 1'b0, 4'h0, 1'b0);

    // 2. Fill: 0..3 stored, 4 dropped.
    for (int i = 0; i < 5; i++) do_cycle("fill", 1'b1, 4'(i), 1'b0);

    // Simultaneous read/write while full: read wins, write dropped.
    do_cycle("full_rw", 1'b1, 4'hE, 1'b1);
    do_cycle("refill", 1'b1, 4'h4, 1'b0);

    // 3. Drain past empty: rdata holds the last word.
    for (int i = 0; i < 5; i++) do_cycle("drain", 1'b0, 4'h0, 1'b1);

    // Simultaneous read/write while empty: write wins, read dropped.
    do_cycle("empty_rw", 1'b1, 4'h9, 1'b1);
    do_cycle("empty_rw2", 1'b0, 4'h0, 1'b1);

    // 4. Interleaved 8 writes / 8 reads: pointers wrap.
    for (int i = 0; i < 8; i++) begin
      do_cycle("wrap_w", 1'b1, 4'(5 + i), 1'b0);
      do_cycle("wrap_r", 1'b0, 4'h0, 1'b1);
    end

    // 5. Two words stored, then 3 simultaneous read/write cycles.
    do_cycle("occ_w", 1'b1, 4'hD, 1'b0);
    do_cycle("occ_w", 1'b1, 4'hC, 1'b0);
    for (int i = 0; i < 3; i++) do_cycle("occ_rw", 1'b1, 4'(1 + i), 1'b1);
    for (int i = 0; i < 3; i++) do_cycle("occ_drain", 1'b0, 4'h0, 1'b1);

    // 6. Asynchronous reset with 3 words stored.
    for (int i = 0; i < 3; i++) do_cycle("pre_rst", 1'b1, 4'(10 + i), 1'b0);
    do_cycle("pre_rst_r", 1'b0, 4'h0, 1'b1);
    do_cycle("pre_rst_w", 1'b1, 4'hB, 1'b0);
    @(negedge w_clk);
    w_en = 1'b0;
    r_en = 1'b0;
    #2;
    wrst_n = 1'b0;
    #1;
    sb_q.delete();
    exp_rdata = 4'h0;
    check_state("mid_rst");
    @(negedge w_clk);
    wrst_n = 1'b1;
    do_cycle("post_rst_rd", 1'b0, 4'h0, 1'b1);
    do_cycle("post_rst_w", 1'b1, 4'h6, 1'b0);
    do_cycle("post_rst_r", 1'b0, 4'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
